// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side watch bus and DMA-side drive bus of the sprite-attribute DMA engine.
// Latency: wires only; timing is owned by the engine (all engine outputs are registered).
// Backpressure: rdy=0 halts the CPU; busy=1 hands the system bus mux to dma_a/dma_rd/dma_wr.
//
// Signals:
//   cpu_a[15:0], cpu_wr, cpu_dout[7:0]   CPU address / write strobe / write data
//   bus_din[7:0]                         system bus read data, valid at the end of a read cycle
//   rdy, busy                            CPU run enable, DMA bus ownership
//   dma_a[15:0], dma_dout[7:0]           DMA address and write data
//   dma_rd, dma_wr                       DMA read / write strobes
// Modports: slave = the DMA engine, master = the CPU/system side that drives and observes it.
interface oam_dma_if;
  logic [15:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        rdy;
  logic        busy;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_rd;
  logic        dma_wr;

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, bus_din,
    output rdy, busy, dma_a, dma_dout, dma_rd, dma_wr
  );

  modport master (
    output cpu_a, cpu_wr, cpu_dout, bus_din,
    input  rdy, busy, dma_a, dma_dout, dma_rd, dma_wr
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: on a CPU write to DMA_REG_ADDR, halts the CPU and copies XFER_LEN bytes from page $PP00 to DEST_ADDR.
// Latency: rdy falls one cycle after the trigger; stall = 1 + ALIGN(0/1) + 2*XFER_LEN cycles, all outputs registered.
// Backpressure: none accepted; the engine stalls the CPU via rdy and owns the bus (busy) during ALIGN/READ/WRITE.
//
// Ports:
//   clk    in  system clock, CPU cycle rate
//   rst_n  in  asynchronous active-low reset; aborts any transfer with no resume
//   bus    oam_dma_if.slave (cpu_a/cpu_wr/cpu_dout/bus_din in; rdy/busy/dma_a/dma_dout/dma_rd/dma_wr out)
// Optional feature: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when the free-running
// parity bit is 1 during HALT; when undefined the parity bit and ALIGN path are absent.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic     clk,
  input  logic     rst_n,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [8:0] LAST_CNT = 9'(XFER_LEN - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_page;
  logic [7:0]  w_page_nx;
  logic [8:0]  r_count;
  logic [8:0]  w_count_nx;
  logic        w_trigger;

  // Registered outputs; their next values are decoded from the next state so every
  // output changes only on the clock edge.
  logic        r_rdy;
  logic        r_busy;
  logic [15:0] r_dma_a;
  logic [7:0]  r_dma_dout;
  logic        r_dma_rd;
  logic        r_dma_wr;
  logic        w_rdy_nx;
  logic        w_busy_nx;
  logic [15:0] w_dma_a_nx;
  logic [7:0]  w_dma_dout_nx;
  logic        w_dma_rd_nx;
  logic        w_dma_wr_nx;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity; decides whether the read/write pairs need one
  // extra cycle to line up with the bus phase.
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
    end
  end
`endif

  assign w_trigger = bus.cpu_wr && (bus.cpu_a == DMA_REG_ADDR);

  always_comb begin
    w_state_nx = r_state;
    w_page_nx  = r_page;
    w_count_nx = r_count;
    case (r_state)
      S_IDLE: begin
        // Triggers are only honoured here, so a second write mid-transfer
        // cannot re-latch the page.
        if (w_trigger) begin
          w_page_nx  = bus.cpu_dout;
          w_count_nx = 9'd0;
          w_state_nx = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        w_state_nx = r_parity ? S_ALIGN : S_READ;
`else
        w_state_nx = S_READ;
`endif
      end
      S_ALIGN: w_state_nx = S_READ;
      S_READ:  w_state_nx = S_WRITE;
      S_WRITE: begin
        w_count_nx = r_count + 9'd1;
        w_state_nx = (r_count == LAST_CNT) ? S_IDLE : S_READ;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdy_nx      = (w_state_nx == S_IDLE);
    w_busy_nx     = (w_state_nx == S_ALIGN) || (w_state_nx == S_READ) || (w_state_nx == S_WRITE);
    w_dma_rd_nx   = (w_state_nx == S_READ);
    w_dma_wr_nx   = (w_state_nx == S_WRITE);
    w_dma_a_nx    = 16'h0000;
    if (w_state_nx == S_READ) begin
      // Only the low 8 count bits address the page: no carry into the page byte.
      w_dma_a_nx = {w_page_nx, w_count_nx[7:0]};
    end else if (w_state_nx == S_WRITE) begin
      w_dma_a_nx = DEST_ADDR;
    end
    // dma_dout doubles as the data latch: loaded at the end of each READ cycle.
    w_dma_dout_nx = (r_state == S_READ) ? bus.bus_din : r_dma_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_page     <= 8'h00;
      r_count    <= 9'd0;
      r_rdy      <= 1'b1;
      r_busy     <= 1'b0;
      r_dma_a    <= 16'h0000;
      r_dma_dout <= 8'h00;
      r_dma_rd   <= 1'b0;
      r_dma_wr   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_page     <= w_page_nx;
      r_count    <= w_count_nx;
      r_rdy      <= w_rdy_nx;
      r_busy     <= w_busy_nx;
      r_dma_a    <= w_dma_a_nx;
      r_dma_dout <= w_dma_dout_nx;
      r_dma_rd   <= w_dma_rd_nx;
      r_dma_wr   <= w_dma_wr_nx;
    end
  end

  assign bus.rdy      = r_rdy;
  assign bus.busy     = r_busy;
  assign bus.dma_a    = r_dma_a;
  assign bus.dma_dout = r_dma_dout;
  assign bus.dma_rd   = r_dma_rd;
  assign bus.dma_wr   = r_dma_wr;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma; a memory model answers DMA reads.
// Latency: expected reads/writes/stall lengths are queued at trigger time and popped as the DUT produces them.
// Backpressure: none; the bench observes rdy/busy and waits with bounded cycle budgets.
`timescale 1ns/1ps
module tb_oam_dma;

  localparam int XFER = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if bus_if();

  oam_dma dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Page $02 holds n^A5 as in the reference transfer; other pages get a page-dependent pattern.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] pg;
    pg = a[15:8];
    if (pg == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ (pg * 8'h11) ^ 8'h3C;
  endfunction

  assign bus_if.bus_din = bus_if.dma_rd ? mem_byte(bus_if.dma_a) : 8'hFF;

  // Parity model: 0 out of reset, toggling on every clock edge thereafter.
  int tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  logic [15:0] q_addr[$];
  logic [7:0]  q_data[$];
  int          q_stall[$];
  int          stall_cnt = 0;
  bit          mon_en = 1'b0;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (!bus_if.busy)
        chk("strobes_idle", {bus_if.dma_rd, bus_if.dma_wr}, 2'b00);
      if (bus_if.dma_rd && bus_if.dma_wr)
        chk("strobes_both", {bus_if.dma_rd, bus_if.dma_wr}, 2'b10);
      if (bus_if.dma_rd) begin
        chk("rd_expected", 32'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) chk("rd_addr", bus_if.dma_a, q_addr.pop_front());
      end
      if (bus_if.dma_wr) begin
        chk("wr_addr", bus_if.dma_a, 16'h2004);
        chk("wr_expected", 32'(q_data.size() > 0), 1);
        if (q_data.size() > 0) chk("wr_data", bus_if.dma_dout, q_data.pop_front());
      end
      if (!bus_if.rdy) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        chk("stall_expected", 32'(q_stall.size() > 0), 1);
        if (q_stall.size() > 0) chk("stall_len", stall_cnt, q_stall.pop_front());
        stall_cnt = 0;
      end
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d);
    @(negedge clk);
    bus_if.cpu_a    = a;
    bus_if.cpu_wr   = wr;
    bus_if.cpu_dout = d;
    @(negedge clk);
    bus_if.cpu_wr   = 1'b0;
    bus_if.cpu_a    = 16'h0000;
  endtask

  // Trigger a transfer so that the HALT cycle sees the requested parity.
  task automatic dma_trigger(input logic [7:0] page, input int want_par);
    int par;
    int align;
    @(negedge clk);
    while (((tb_cyc + 1) & 1) != want_par) @(negedge clk);
    par = (tb_cyc + 1) & 1;
`ifdef OAM_DMA_ALIGN_EN
    align = par;
`else
    align = 0;
`endif
    for (int n = 0; n < XFER; n++) begin
      logic [15:0] a;
      a = {page, 8'(n)};
      q_addr.push_back(a);
      q_data.push_back(mem_byte(a));
    end
    q_stall.push_back(1 + align + 2 * XFER);
    bus_if.cpu_a    = 16'h4014;
    bus_if.cpu_wr   = 1'b1;
    bus_if.cpu_dout = page;
    @(negedge clk);
    bus_if.cpu_wr   = 1'b0;
    bus_if.cpu_a    = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_if.rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(n < 2000), 1);
    @(negedge clk);
    chk({tag, "_q_addr_empty"}, q_addr.size(), 0);
    chk({tag, "_q_data_empty"}, q_data.size(), 0);
    chk({tag, "_q_stall_empty"}, q_stall.size(), 0);
    chk({tag, "_rdy_after"}, bus_if.rdy, 1);
    chk({tag, "_busy_after"}, bus_if.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, bus_if.rdy, 1);
    chk({tag, "_busy"}, bus_if.busy, 0);
    chk({tag, "_rd"}, bus_if.dma_rd, 0);
    chk({tag, "_wr"}, bus_if.dma_wr, 0);
    chk({tag, "_dma_a"}, bus_if.dma_a, 16'h0000);
    chk({tag, "_dma_dout"}, bus_if.dma_dout, 8'h00);
  endtask

  initial begin
    int n;
    bus_if.cpu_a    = 16'h4014;
    bus_if.cpu_wr   = 1'b1;
    bus_if.cpu_dout = 8'h02;
    // A trigger held during reset must have no effect.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    bus_if.cpu_wr = 1'b0;
    bus_if.cpu_a  = 16'h0000;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_reset_rdy", bus_if.rdy, 1);

    // Non-trigger accesses: write to $4015, read of $4014.
    cpu_cycle(16'h4015, 1'b1, 8'h02);
    cpu_cycle(16'h4014, 1'b0, 8'h02);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nontrig_rdy", bus_if.rdy, 1);
      chk("nontrig_busy", bus_if.busy, 0);
    end

    // Reference transfer from page $02, even parity at HALT.
    dma_trigger(8'h02, 0);
    wait_idle("page02_even");

    // Odd parity at HALT.
    dma_trigger(8'h06, 1);
    wait_idle("page06_odd");

    // Page $03 with a stray $4014 write (data $07) mid-transfer.
    dma_trigger(8'h03, 0);
    repeat (40) @(negedge clk);
    chk("midxfer_busy", bus_if.busy, 1);
    cpu_cycle(16'h4014, 1'b1, 8'h07);
    wait_idle("page03_ignore");

    // Reset during the READ of byte 100, then a fresh transfer from page $05.
    dma_trigger(8'h04, 0);
    n = 0;
    while (!(bus_if.dma_rd && bus_if.dma_a == 16'h0464) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_point_found", 32'(n < 2000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    q_addr.delete();
    q_data.delete();
    q_stall.delete();
    stall_cnt = 0;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_rdy_after", bus_if.rdy, 1);
    chk("midreset_busy_after", bus_if.busy, 0);
    dma_trigger(8'h05, 1);
    wait_idle("page05_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-attribute DMA engine on the 6502 bus, directly downstream of the CPU core's address/data outputs. It watches CPU writes; a write to the DMA register halts the CPU through `rdy` and then drives the bus to copy 256 bytes from page `$PP00–$PPFF` to the PPU OAM data port. When the copy finishes it releases the CPU. The system bus mux selects the DMA address/strobes whenever `busy` is high.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers a transfer
- `DEST_ADDR`, 16'h2004, fixed destination address for every write
- `XFER_LEN`, 256, bytes per transfer (1–256)

Ports:
- `clk`  in  1  system clock, CPU cycle rate
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_a`  in  16  CPU address bus
- `cpu_wr`  in  1  CPU write strobe, valid this cycle
- `cpu_dout`  in  8  CPU write data
- `bus_din`  in  8  read data returned from the system bus, valid at end of a read cycle
- `rdy`  out  1  1 = CPU runs; 0 = CPU halted
- `busy`  out  1  1 = DMA owns the bus (`dma_a`/`dma_rd`/`dma_wr` are selected)
- `dma_a`  out  16  DMA bus address
- `dma_dout`  out  8  DMA write data
- `dma_rd`  out  1  DMA read strobe
- `dma_wr`  out  1  DMA write strobe

## Operation
- Trigger: `cpu_wr && cpu_a == DMA_REG_ADDR` in IDLE latches `cpu_dout` as page `PP`, count = 0, next state HALT.
- States: IDLE → HALT → (ALIGN) → READ ⇄ WRITE → IDLE.
  - IDLE: `rdy`=1, `busy`=0, strobes 0.
  - HALT: `rdy`=0, `busy`=0, no strobes; absorbs the CPU's in-flight cycle.
  - ALIGN (only if `parity`=1 at HALT, see Configuration): one idle cycle, `rdy`=0, `busy`=1.
  - READ: `dma_a` = {PP, count[7:0]}, `dma_rd`=1; `bus_din` captured into data latch on clock edge.
  - WRITE: `dma_a` = DEST_ADDR, `dma_wr`=1, `dma_dout` = data latch; count increments. count == XFER_LEN−1 → IDLE, else READ.
- `parity`: free-running 1-bit toggle each clock from reset (0 after reset).
- Triggering writes while not IDLE are ignored (page not re-latched).
- Count is 9 bits internally; address uses low 8 bits, no carry into the page byte.
- Reset mid-transfer: immediately IDLE, `rdy`=1, `busy`=0, strobes 0; no resume.

## Timing
- Reset values: `rdy`=1, `busy`=0, `dma_a`=16'h0000, `dma_dout`=8'h00, `dma_rd`=0, `dma_wr`=0, `parity`=0.
- All outputs registered; change only on `clk` rising edge.
- `rdy` falls the cycle after the trigger write; rises the cycle after the last WRITE.
- Halted length (cycles with `rdy`=0): 1 + ALIGN(0/1) + 2·XFER_LEN → 513 or 514 for 256 bytes.
- `dma_rd` and `dma_wr` never both 1; never asserted while `busy`=0.
- `busy`=1 exactly on ALIGN, READ and WRITE cycles.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: ALIGN state inserted when `parity`=1 in HALT (513/514-cycle stall, matches hardware).
- Undefined: ALIGN never entered; stall is always 1 + 2·XFER_LEN cycles; `parity` logic removed.

## Test plan
- Reset: hold `rst_n`=0 → `rdy`=1, `busy`=0, all strobes 0, `dma_a`=0000.
- Write 8'h02 to $4014 with memory $0200+n = n^8'hA5 → 256 writes to $2004 with data 8'hA5, 8'hA4, … in order; `dma_a` on reads $0200…$02FF.
- Trigger on even vs odd `parity` with `OAM_DMA_ALIGN_EN` → `rdy` low 513 vs 514 cycles; without macro both 513.
- Second $4014 write (data 8'h07) injected mid-transfer of page $03 → ignored, all reads still $03xx.
- Assert `rst_n`=0 during READ of byte 100 → next edge IDLE, `rdy`=1; new trigger page $05 runs full 256 bytes from $0500.
- CPU writes to $4015 and reads of $4014 → no state change, `rdy` stays 1.
